// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - mult/div launch sequencer with architectural HI/LO registers
module hilo_sequencer #(
  parameter int MAX_CYCLES = 34
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        md_start,
  input  logic        mdControl,
  input  logic [31:0] regA_out,
  input  logic [31:0] regB_out,
  input  logic [31:0] hi_entrance,
  input  logic [31:0] lo_entrance,
  input  logic        md_done,
  input  logic        mthi_wr,
  input  logic        mtlo_wr,
  output logic        md_go,
  output logic        md_op,
  output logic        md_busy,
  output logic        md_ready,
  output logic        div_zero,
  output logic        md_timeout,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  localparam logic [5:0] LAST = 6'(MAX_CYCLES - 1);

  state_t     state, state_nx;
  logic [5:0] count, count_nx;
  logic       accept, reject, commit, expire;

  always_comb begin
    state_nx = state;
    count_nx = count;
    accept   = 1'b0;
    reject   = 1'b0;
    commit   = 1'b0;
    expire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (md_start) begin
          // A div by zero is screened here so multDiv is never started on it
          if (mdControl && regB_out == 32'd0) begin
            reject = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        count_nx = 6'd0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (md_done) begin
          commit   = 1'b1;
          state_nx = S_IDLE;
        end else if (count == LAST) begin
          expire   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          count_nx = count + 6'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= 6'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  assign md_busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_go      <= 1'b0;
      md_op      <= 1'b0;
      md_ready   <= 1'b0;
      div_zero   <= 1'b0;
      md_timeout <= 1'b0;
      hi_out     <= 32'd0;
      lo_out     <= 32'd0;
    end else begin
      md_go      <= accept;
      md_ready   <= commit;
      div_zero   <= reject;
      md_timeout <= expire;
      if (accept) md_op <= mdControl;
      // Register moves only land in IDLE; a commit always wins later
      if (commit) begin
        hi_out <= hi_entrance;
        lo_out <= lo_entrance;
      end else if (state == S_IDLE) begin
        if (mthi_wr) hi_out <= regA_out;
        if (mtlo_wr) lo_out <= regA_out;
      end
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb/tb_hilo_sequencer.sv - randomized and directed self-checking bench for hilo_sequencer
module tb_hilo_sequencer;

  localparam int MAXC = 34;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        md_start = 1'b0, mdControl = 1'b0, md_done = 1'b0;
  logic        mthi_wr = 1'b0, mtlo_wr = 1'b0;
  logic [31:0] regA_out = '0, regB_out = '0, hi_entrance = '0, lo_entrance = '0;
  logic        md_go, md_op, md_busy, md_ready, div_zero, md_timeout;
  logic [31:0] hi_out, lo_out;

  hilo_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset), .md_start(md_start), .mdControl(mdControl),
    .regA_out(regA_out), .regB_out(regB_out), .hi_entrance(hi_entrance),
    .lo_entrance(lo_entrance), .md_done(md_done), .mthi_wr(mthi_wr), .mtlo_wr(mtlo_wr),
    .md_go(md_go), .md_op(md_op), .md_busy(md_busy), .md_ready(md_ready),
    .div_zero(div_zero), .md_timeout(md_timeout), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference: an operation in flight plus the number of edges since it was accepted
  bit          m_active;
  int          m_elapsed;
  bit          m_op, m_go, m_ready, m_dz, m_to;
  logic [31:0] m_hi, m_lo;
  int          go_count, ready_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_elapsed = 0; m_op = 0; m_go = 0; m_ready = 0;
    m_dz = 0; m_to = 0; m_hi = '0; m_lo = '0;
  endtask

  task automatic model_step();
    m_go = 0; m_ready = 0; m_dz = 0; m_to = 0;
    if (!m_active) begin
      if (mthi_wr) m_hi = regA_out;
      if (mtlo_wr) m_lo = regA_out;
      if (md_start) begin
        if (mdControl && regB_out == 0) m_dz = 1;
        else begin m_active = 1; m_elapsed = 0; m_op = mdControl; m_go = 1; end
      end
    end else if (m_elapsed == 0) begin
      m_elapsed = 1;
    end else if (md_done) begin
      m_hi = hi_entrance; m_lo = lo_entrance; m_active = 0; m_ready = 1;
    end else if (m_elapsed == MAXC) begin
      m_active = 0; m_to = 1;
    end else begin
      m_elapsed++;
    end
  endtask

  task automatic check_all();
    check("md_go", 32'(md_go), 32'(m_go));
    check("md_op", 32'(md_op), 32'(m_op));
    check("md_busy", 32'(md_busy), 32'(m_active));
    check("md_ready", 32'(md_ready), 32'(m_ready));
    check("div_zero", 32'(div_zero), 32'(m_dz));
    check("md_timeout", 32'(md_timeout), 32'(m_to));
    check("hi_out", hi_out, m_hi);
    check("lo_out", lo_out, m_lo);
    if (md_go) go_count++;
    if (md_ready) ready_count++;
  endtask

  task automatic cycle(input bit st, input bit ctl, input logic [31:0] a, input logic [31:0] b,
                       input bit dn, input logic [31:0] he, input logic [31:0] le,
                       input bit wh, input bit wl);
    md_start = st; mdControl = ctl; regA_out = a; regB_out = b;
    md_done = dn; hi_entrance = he; lo_entrance = le; mthi_wr = wh; mtlo_wr = wl;
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 1'b1;

    // mult 3*5 with done on the third WAIT cycle
    go_count = 0; ready_count = 0;
    cycle(1, 0, 32'd3, 32'd5, 0, '0, '0, 0, 0);
    idle_cycles(3);
    cycle(0, 0, '0, '0, 1, 32'd0, 32'hF, 0, 0);
    idle_cycles(2);
    check("mult_lo", lo_out, 32'hF);
    check("mult_go_once", 32'(go_count), 32'd1);
    check("mult_ready_once", 32'(ready_count), 32'd1);

    // div by zero rejected
    cycle(1, 1, 32'd7, 32'd0, 0, '0, '0, 0, 0);
    idle_cycles(2);

    // div timeout, then a normal mult
    cycle(1, 1, 32'd9, 32'd2, 0, '0, '0, 0, 0);
    idle_cycles(MAXC + 2);
    cycle(1, 0, 32'd2, 32'd2, 0, '0, '0, 0, 0);
    idle_cycles(1);
    cycle(0, 0, '0, '0, 1, 32'h1, 32'h4, 0, 0);

    // mthi in IDLE, mtlo dropped during WAIT
    cycle(0, 0, 32'hDEADBEEF, '0, 0, '0, '0, 1, 0);
    check("mthi_direct", hi_out, 32'hDEADBEEF);
    cycle(1, 0, 32'd5, 32'd6, 0, '0, '0, 0, 0);
    idle_cycles(1);
    cycle(0, 0, 32'h1234, '0, 0, '0, '0, 0, 1);
    cycle(0, 0, '0, '0, 1, 32'h0, 32'h1E, 0, 0);
    check("mtlo_dropped", lo_out, 32'h1E);

    // second start during WAIT is ignored
    go_count = 0; ready_count = 0;
    cycle(1, 0, 32'd1, 32'd1, 0, '0, '0, 0, 0);
    idle_cycles(1);
    cycle(1, 1, 32'd8, 32'd4, 0, '0, '0, 0, 0);
    cycle(0, 0, '0, '0, 1, 32'hAA, 32'hBB, 0, 0);
    idle_cycles(2);
    check("dup_go_once", 32'(go_count), 32'd1);
    check("dup_ready_once", 32'(ready_count), 32'd1);

    // reset mid-WAIT, then a stray md_done
    cycle(1, 1, 32'd8, 32'd4, 0, '0, '0, 0, 0);
    idle_cycles(3);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b1;
    cycle(0, 0, '0, '0, 1, 32'h55, 32'h66, 0, 0);
    idle_cycles(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(7) == 0), $urandom_range(1), $urandom,
            ($urandom_range(3) == 0) ? 32'd0 : $urandom,
            ($urandom_range(11) == 0), $urandom, $urandom,
            ($urandom_range(9) == 0), ($urandom_range(9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
